dcache_line_wb: RTL and testbench

- Single parametrised write-back data-cache line: one tag, LINEWORDS data words in an internal dual-port RAM, plus dirty bit, valid state and TTL ageing counter.
- Serves core read/write requests with byte enables; reports misses and TTL to the replacement controller.
- On fill_req it writes back the old contents if dirty, then refills from memory in bursts.
- Sits between the dcache arbiter (one instance per way/line) and the memory burst interface.

---
 rtl/dcache_line_wb_if.sv | 44 ++++
 rtl/dcache_line_wb.sv | 207 ++++++++++++++++++++
 tb/tb_dcache_line_wb.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_line_wb_if.sv
// Core-request and memory-burst signals for one write-back cache line.
// The slave modport is the cache line; the master modport is the arbiter/memory side.
interface dcache_line_wb_if #(
    parameter int unsigned ADDRBITS = 32,
    parameter int unsigned DATABITS = 32,
    parameter int unsigned TTLBITS  = 8
);
    localparam int unsigned WB = DATABITS / 8;

    logic [ADDRBITS-1:0] req_addr;
    logic                req_rd;
    logic                req_wr;
    logic [WB-1:0]       req_be;
    logic [DATABITS-1:0] req_wdata;
    logic [DATABITS-1:0] rsp_rdata;
    logic                rsp_valid;
    logic                miss;
    logic [TTLBITS-1:0]  ttl;
    logic                dirty;
    logic                busy;
    logic                fill_req;
    logic [ADDRBITS-1:0] mem_addr;
    logic                mem_rdreq;
    logic [15:0]         mem_burstlen;
    logic [DATABITS-1:0] mem_rdata;
    logic                mem_rvalid;
    logic                mem_wrreq;
    logic [DATABITS-1:0] mem_wdata;
    logic                mem_wready;

    modport slave (
        input  req_addr, req_rd, req_wr, req_be, req_wdata, fill_req,
               mem_burstlen, mem_rdata, mem_rvalid, mem_wready,
        output rsp_rdata, rsp_valid, miss, ttl, dirty, busy,
               mem_addr, mem_rdreq, mem_wrreq, mem_wdata
    );

    modport master (
        output req_addr, req_rd, req_wr, req_be, req_wdata, fill_req,
               mem_burstlen, mem_rdata, mem_rvalid, mem_wready,
        input  rsp_rdata, rsp_valid, miss, ttl, dirty, busy,
               mem_addr, mem_rdreq, mem_wrreq, mem_wdata
    );
endinterface

// File: rtl/dcache_line_wb.sv
// Single write-back data-cache line: tag, data RAM, dirty/valid state and TTL ageing.
// Flushes the old line when dirty, then refills it from memory in bursts.
module dcache_line_wb #(
    parameter int unsigned ADDRBITS     = 32,
    parameter int unsigned DATABITS     = 32,
    parameter int unsigned LINEWORDS    = 32,
    parameter int unsigned LINEADDRBITS = 5,
    parameter int unsigned TTLBITS      = 8,
    parameter int unsigned MAXTTL       = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    dcache_line_wb_if.slave bus
);
    localparam int unsigned WB      = DATABITS / 8;
    localparam int unsigned BOFS    = $clog2(WB);
    localparam int unsigned TAGBITS = ADDRBITS - LINEADDRBITS - BOFS;
    localparam int unsigned CNTW    = LINEADDRBITS + 1;
    localparam int unsigned BLXW    = 17;

    typedef enum logic [1:0] {
        S_INIT,
        S_VALID,
        S_FLUSH,
        S_FILL
    } state_t;

    state_t state;

    logic [DATABITS-1:0]     ram [LINEWORDS];
    logic [TAGBITS-1:0]      tag;
    logic [TAGBITS-1:0]      wb_tag;
    logic [CNTW-1:0]         cnt_wb;
    logic [CNTW-1:0]         cnt_fill;
    logic [CNTW-1:0]         burst_left;

    logic [DATABITS-1:0]     rsp_rdata_q;
    logic                    rsp_valid_q;
    logic                    miss_q;
    logic [TTLBITS-1:0]      ttl_q;
    logic                    dirty_q;
    logic                    busy_q;
    logic [ADDRBITS-1:0]     mem_addr_q;
    logic                    mem_rdreq_q;
    logic                    mem_wrreq_q;
    logic [DATABITS-1:0]     mem_wdata_q;

    logic [TAGBITS-1:0]      req_tag;
    logic [LINEADDRBITS-1:0] req_idx;
    logic [LINEADDRBITS-1:0] rd_idx;
    logic [DATABITS-1:0]     rd_word;
    logic [DATABITS-1:0]     merged;
    logic [CNTW-1:0]         cnt_wb_next;
    logic [CNTW-1:0]         cnt_fill_next;
    logic [CNTW-1:0]         burst_len;
    logic [BLXW-1:0]         len_req;
    logic [BLXW-1:0]         len_rem;
    logic                    any_req;
    logic                    tag_match;
    logic                    hit;
    logic                    hit_wr;
    logic                    fill_we;
    logic                    unused_lsbs;

    assign req_tag       = bus.req_addr[ADDRBITS-1:LINEADDRBITS+BOFS];
    assign req_idx       = bus.req_addr[LINEADDRBITS+BOFS-1:BOFS];
    assign unused_lsbs   = ^bus.req_addr[BOFS-1:0];
    assign any_req       = bus.req_rd | bus.req_wr;
    assign tag_match     = (req_tag == tag);
    assign hit           = (state == S_VALID) && any_req && tag_match;
    assign hit_wr        = hit && bus.req_wr;
    assign fill_we       = (state == S_FILL) && bus.mem_rvalid && (burst_left != '0);
    assign cnt_wb_next   = cnt_wb + CNTW'(1);
    assign cnt_fill_next = cnt_fill + CNTW'(1);

    // Single read port: flush streams words out, otherwise the request index is read.
    always_comb begin
        rd_idx = req_idx;
        if (state == S_FLUSH) begin
            rd_idx = mem_wrreq_q ? cnt_wb_next[LINEADDRBITS-1:0] : cnt_wb[LINEADDRBITS-1:0];
        end
    end

    assign rd_word = ram[rd_idx];

    always_comb begin
        merged = rd_word;
        for (int b = 0; b < WB; b++) begin
            if (bus.req_be[b]) merged[b*8 +: 8] = bus.req_wdata[b*8 +: 8];
        end
    end

    // Burst length: zero means one word, never past the end of the line.
    always_comb begin
        len_req   = (bus.mem_burstlen == 16'd0) ? BLXW'(1) : BLXW'(bus.mem_burstlen);
        len_rem   = BLXW'(LINEWORDS) - BLXW'(cnt_fill);
        burst_len = (len_req < len_rem) ? CNTW'(len_req) : CNTW'(len_rem);
    end

    always_ff @(posedge clk) begin
        if (hit_wr) begin
            ram[req_idx] <= merged;
        end else if (fill_we) begin
            ram[cnt_fill[LINEADDRBITS-1:0]] <= bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_INIT;
            tag         <= '0;
            wb_tag      <= '0;
            cnt_wb      <= '0;
            cnt_fill    <= '0;
            burst_left  <= '0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
            miss_q      <= 1'b1;
            ttl_q       <= '0;
            dirty_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_rdreq_q <= 1'b0;
            mem_wrreq_q <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            mem_rdreq_q <= 1'b0;
            rsp_valid_q <= hit;
            miss_q      <= (state != S_VALID) || (any_req && !tag_match);
            if (hit) rsp_rdata_q <= rd_word;

            case (state)
                S_INIT: begin
                    if (bus.fill_req) begin
                        tag        <= req_tag;
                        cnt_fill   <= '0;
                        burst_left <= '0;
                        busy_q     <= 1'b1;
                        state      <= S_FILL;
                    end
                end

                S_VALID: begin
                    if (any_req && !tag_match && ttl_q != '0) ttl_q <= ttl_q - TTLBITS'(1);
                    if (hit_wr) dirty_q <= 1'b1;
                    // The hit above completes first; a same-cycle write forces a flush.
                    if (bus.fill_req) begin
                        wb_tag     <= tag;
                        tag        <= req_tag;
                        cnt_wb     <= '0;
                        cnt_fill   <= '0;
                        burst_left <= '0;
                        busy_q     <= 1'b1;
                        state      <= (dirty_q || hit_wr) ? S_FLUSH : S_FILL;
                    end
                end

                S_FLUSH: begin
                    if (!mem_wrreq_q) begin
                        mem_wrreq_q <= 1'b1;
                        mem_addr_q  <= {wb_tag, cnt_wb[LINEADDRBITS-1:0], {BOFS{1'b0}}};
                        mem_wdata_q <= rd_word;
                    end else if (bus.mem_wready) begin
                        cnt_wb <= cnt_wb_next;
                        if (cnt_wb_next == CNTW'(LINEWORDS)) begin
                            mem_wrreq_q <= 1'b0;
                            state       <= S_FILL;
                        end else begin
                            mem_addr_q  <= {wb_tag, cnt_wb_next[LINEADDRBITS-1:0], {BOFS{1'b0}}};
                            mem_wdata_q <= rd_word;
                        end
                    end
                end

                S_FILL: begin
                    if (burst_left == '0) begin
                        mem_rdreq_q <= 1'b1;
                        mem_addr_q  <= {tag, cnt_fill[LINEADDRBITS-1:0], {BOFS{1'b0}}};
                        burst_left  <= burst_len;
                    end else if (bus.mem_rvalid) begin
                        cnt_fill   <= cnt_fill_next;
                        burst_left <= burst_left - CNTW'(1);
                        if (cnt_fill_next == CNTW'(LINEWORDS)) begin
                            ttl_q   <= TTLBITS'(MAXTTL);
                            dirty_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state   <= S_VALID;
                        end
                    end
                end

                default: state <= S_INIT;
            endcase
        end
    end

    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.miss      = miss_q;
    assign bus.ttl       = ttl_q;
    assign bus.dirty     = dirty_q;
    assign bus.busy      = busy_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rdreq = mem_rdreq_q;
    assign bus.mem_wrreq = mem_wrreq_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dcache_line_wb.sv
// Scoreboard bench for dcache_line_wb: memory model, read-response and write-back monitors.
module tb_dcache_line_wb;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    dcache_line_wb_if #(.ADDRBITS(32), .DATABITS(32), .TTLBITS(8)) bus ();

    dcache_line_wb dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int rdreq_cnt = 0;
    int wr_cnt    = 0;

    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_rdreq_q[$];
    logic [63:0] exp_wr_q[$];
    logic [31:0] line_model[32];

    logic [31:0] mr_addr, mr_exp;
    int          mr_n, mr_rem;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_data;
    logic [63:0] wr_exp;
    logic [31:0] rd_exp;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return 32'hA000_0000 + ((a - 32'h0000_1000) >> 2);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Memory burst-read model: answers each mem_rdreq with consecutive words.
    always begin
        @(negedge clk);
        if (reset_n === 1'b1 && bus.mem_rdreq === 1'b1) begin
            mr_addr = bus.mem_addr;
            rdreq_cnt++;
            n_checks++;
            if (exp_rdreq_q.size() == 0) begin
                $display("FAIL rdreq_addr: unexpected burst request at %h", mr_addr);
            end else begin
                mr_exp = exp_rdreq_q.pop_front();
                if (mr_addr !== mr_exp)
                    $display("FAIL rdreq_addr: got %h expected %h", mr_addr, mr_exp);
                else n_pass++;
            end
            mr_n   = (bus.mem_burstlen == 16'd0) ? 1 : int'(bus.mem_burstlen);
            mr_rem = 32 - int'((mr_addr >> 2) & 32'd31);
            if (mr_n > mr_rem) mr_n = mr_rem;
            for (int k = 0; k < mr_n; k++) begin
                if (reset_n !== 1'b1) break;
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = memval(mr_addr + 32'(4 * k));
                @(negedge clk);
            end
            bus.mem_rvalid = 1'b0;
        end
    end

    // Write-back monitor: toggles mem_wready, checks hold-while-stalled and accepted words.
    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            bus.mem_wready = 1'b0;
            prev_stall     = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (bus.mem_wrreq !== 1'b1 || bus.mem_addr !== prev_addr || bus.mem_wdata !== prev_data)
                    $display("FAIL wr_stable: got req=%b %h/%h expected 1 %h/%h",
                             bus.mem_wrreq, bus.mem_addr, bus.mem_wdata, prev_addr, prev_data);
                else n_pass++;
            end
            bus.mem_wready = ~bus.mem_wready;
            if (bus.mem_wrreq === 1'b1 && bus.mem_wready === 1'b1) begin
                wr_cnt++;
                n_checks++;
                if (exp_wr_q.size() == 0) begin
                    $display("FAIL wr_word: unexpected write %h/%h", bus.mem_addr, bus.mem_wdata);
                end else begin
                    wr_exp = exp_wr_q.pop_front();
                    if ({bus.mem_addr, bus.mem_wdata} !== wr_exp)
                        $display("FAIL wr_word: got %h/%h expected %h/%h",
                                 bus.mem_addr, bus.mem_wdata, wr_exp[63:32], wr_exp[31:0]);
                    else n_pass++;
                end
            end
            prev_stall = (bus.mem_wrreq === 1'b1) && !bus.mem_wready;
            prev_addr  = bus.mem_addr;
            prev_data  = bus.mem_wdata;
        end
    end

    // Read-response monitor: every rsp_valid consumes one expected word.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.rsp_valid === 1'b1) begin
            n_checks++;
            if (exp_rd_q.size() == 0) begin
                $display("FAIL rsp_rdata: unexpected response %h", bus.rsp_rdata);
            end else begin
                rd_exp = exp_rd_q.pop_front();
                if (bus.rsp_rdata !== rd_exp)
                    $display("FAIL rsp_rdata: got %h expected %h", bus.rsp_rdata, rd_exp);
                else n_pass++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [3:0] be, input logic [31:0] wd, input logic fill);
        @(negedge clk);
        bus.req_addr  = addr;
        bus.req_rd    = rd;
        bus.req_wr    = wr;
        bus.req_be    = be;
        bus.req_wdata = wd;
        bus.fill_req  = fill;
        @(negedge clk);
        bus.req_rd   = 1'b0;
        bus.req_wr   = 1'b0;
        bus.req_be   = 4'h0;
        bus.fill_req = 1'b0;
        #1;
    endtask

    task automatic wait_idle(input int budget, output logic ok);
        int c = 0;
        while (bus.busy !== 1'b0 && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        ok = (bus.busy === 1'b0);
    endtask

    task automatic load_model(input logic [31:0] base);
        for (int i = 0; i < 32; i++) line_model[i] = memval(base + 32'(4 * i));
    endtask

    task automatic test_reset();
        reset_n          = 1'b0;
        bus.req_addr     = '0;
        bus.req_rd       = 1'b0;
        bus.req_wr       = 1'b0;
        bus.req_be       = '0;
        bus.req_wdata    = '0;
        bus.fill_req     = 1'b0;
        bus.mem_burstlen = 16'd8;
        bus.mem_rdata    = '0;
        bus.mem_rvalid   = 1'b0;
        idle(3);
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.miss, bus.dirty, bus.busy, bus.mem_rdreq, bus.mem_wrreq} !== 6'b010000)
            $display("FAIL reset_flags: got %b expected 010000",
                     {bus.rsp_valid, bus.miss, bus.dirty, bus.busy, bus.mem_rdreq, bus.mem_wrreq});
        else n_pass++;
        n_checks++;
        if (bus.ttl !== 8'd0) $display("FAIL reset_ttl: got %0d expected 0", bus.ttl);
        else n_pass++;
        n_checks++;
        if (bus.mem_addr !== 32'd0 || bus.rsp_rdata !== 32'd0)
            $display("FAIL reset_regs: got %h/%h expected 0/0", bus.mem_addr, bus.rsp_rdata);
        else n_pass++;
        idle(1);
        reset_n = 1'b1;
        drive(32'h0000_1000, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
        n_checks++;
        if (bus.miss !== 1'b1 || bus.rsp_valid !== 1'b0)
            $display("FAIL init_read: got miss=%b valid=%b expected 1/0", bus.miss, bus.rsp_valid);
        else n_pass++;
    endtask

    task automatic test_fill();
        logic ok;
        bus.mem_burstlen = 16'd8;
        rdreq_cnt = 0;
        for (int i = 0; i < 4; i++) exp_rdreq_q.push_back(32'h0000_1000 + 32'(32 * i));
        load_model(32'h0000_1000);
        drive(32'h0000_1000, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL fill_busy: got %b expected 1", bus.busy);
        else n_pass++;
        wait_idle(400, ok);
        n_checks++;
        if (!ok) $display("FAIL fill_timeout: busy still %b expected 0", bus.busy);
        else n_pass++;
        n_checks++;
        if (rdreq_cnt !== 4 || exp_rdreq_q.size() !== 0)
            $display("FAIL fill_bursts: got %0d pending %0d expected 4/0", rdreq_cnt, exp_rdreq_q.size());
        else n_pass++;
        n_checks++;
        if (bus.ttl !== 8'd255 || bus.dirty !== 1'b0)
            $display("FAIL fill_state: got ttl=%0d dirty=%b expected 255/0", bus.ttl, bus.dirty);
        else n_pass++;
        idle(1);
        n_checks++;
        if (bus.miss !== 1'b0) $display("FAIL valid_idle_miss: got %b expected 0", bus.miss);
        else n_pass++;
    endtask

    task automatic test_read_hit();
        logic [31:0] addrs [3];
        addrs = '{32'h0000_1014, 32'h0000_1000, 32'h0000_107C};
        foreach (addrs[i]) begin
            exp_rd_q.push_back(line_model[addrs[i][6:2]]);
            drive(addrs[i], 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
            n_checks++;
            if (bus.miss !== 1'b0 || bus.rsp_valid !== 1'b1)
                $display("FAIL read_hit: got miss=%b valid=%b expected 0/1", bus.miss, bus.rsp_valid);
            else n_pass++;
        end
        n_checks++;
        if (exp_rd_q.size() !== 0) $display("FAIL read_drain: got %0d pending expected 0", exp_rd_q.size());
        else n_pass++;
    endtask

    task automatic test_write_hit();
        exp_rd_q.push_back(line_model[2]);
        line_model[2] = merge(line_model[2], 4'b0011, 32'hFFFF_1234);
        drive(32'h0000_1008, 1'b0, 1'b1, 4'b0011, 32'hFFFF_1234, 1'b0);
        n_checks++;
        if (bus.dirty !== 1'b1 || bus.rsp_valid !== 1'b1)
            $display("FAIL write_hit: got dirty=%b valid=%b expected 1/1", bus.dirty, bus.rsp_valid);
        else n_pass++;
        exp_rd_q.push_back(line_model[3]);
        line_model[3] = merge(line_model[3], 4'b1000, 32'h5566_7788);
        drive(32'h0000_100C, 1'b1, 1'b1, 4'b1000, 32'h5566_7788, 1'b0);
        exp_rd_q.push_back(32'hA000_1234);
        drive(32'h0000_1008, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
        exp_rd_q.push_back(32'h5500_0003);
        drive(32'h0000_100C, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
        n_checks++;
        if (exp_rd_q.size() !== 0) $display("FAIL write_drain: got %0d pending expected 0", exp_rd_q.size());
        else n_pass++;
    endtask

    task automatic test_miss();
        for (int i = 0; i < 3; i++) begin
            drive(32'h0000_2000, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
            n_checks++;
            if (bus.miss !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.ttl !== 8'(254 - i))
                $display("FAIL miss_%0d: got miss=%b valid=%b ttl=%0d expected 1/0/%0d",
                         i, bus.miss, bus.rsp_valid, bus.ttl, 254 - i);
            else n_pass++;
        end
    endtask

    task automatic flush_and_fill(input logic [31:0] old_base, input logic [31:0] new_base,
                                  input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                                  input string name);
        logic ok;
        if (wr) begin
            exp_rd_q.push_back(line_model[addr[6:2]]);
            line_model[addr[6:2]] = merge(line_model[addr[6:2]], 4'hF, wd);
        end
        for (int i = 0; i < 32; i++) exp_wr_q.push_back({old_base + 32'(4 * i), line_model[i]});
        for (int i = 0; i < 4; i++) exp_rdreq_q.push_back(new_base + 32'(32 * i));
        wr_cnt = 0;
        rdreq_cnt = 0;
        bus.mem_burstlen = 16'd8;
        drive(addr, 1'b0, wr, 4'hF, wd, 1'b1);
        wait_idle(1000, ok);
        n_checks++;
        if (!ok) $display("FAIL %s_timeout: busy still %b expected 0", name, bus.busy);
        else n_pass++;
        n_checks++;
        if (wr_cnt !== 32 || exp_wr_q.size() !== 0 || rdreq_cnt !== 4 || exp_rdreq_q.size() !== 0)
            $display("FAIL %s_counts: got wr=%0d wpend=%0d rd=%0d rpend=%0d expected 32/0/4/0",
                     name, wr_cnt, exp_wr_q.size(), rdreq_cnt, exp_rdreq_q.size());
        else n_pass++;
        n_checks++;
        if (bus.dirty !== 1'b0 || bus.ttl !== 8'd255 || bus.mem_wrreq !== 1'b0)
            $display("FAIL %s_state: got dirty=%b ttl=%0d wrreq=%b expected 0/255/0",
                     name, bus.dirty, bus.ttl, bus.mem_wrreq);
        else n_pass++;
        load_model(new_base);
    endtask

    task automatic test_flush();
        flush_and_fill(32'h0000_1000, 32'h0000_2000, 32'h0000_2000, 1'b0, 32'h0, "flush");
        exp_rd_q.push_back(32'hA000_0405);
        drive(32'h0000_2014, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
        n_checks++;
        if (exp_rd_q.size() !== 0) $display("FAIL flush_refill_read: got %0d pending expected 0", exp_rd_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        // Clean line, write hit with fill_req in the same cycle: the write must be flushed.
        flush_and_fill(32'h0000_2000, 32'h0000_2000, 32'h0000_2000, 1'b1, 32'hDEAD_BEEF, "hit_fill");
        for (int i = 0; i < 4; i++) exp_rd_q.push_back(memval(32'h0000_2000 + 32'(4 * i)));
        @(negedge clk);
        bus.req_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr = 32'h0000_2000 + 32'(4 * i);
            @(negedge clk);
        end
        bus.req_rd = 1'b0;
        #1;
        n_checks++;
        if (exp_rd_q.size() !== 0) $display("FAIL b2b_reads: got %0d pending expected 0", exp_rd_q.size());
        else n_pass++;
    endtask

    task automatic test_burstlen();
        logic        ok;
        logic [15:0] lens [2];
        logic [31:0] bases [2];
        int          nexp [2];
        lens  = '{16'd0, 16'd100};
        bases = '{32'h0000_1000, 32'h0000_2000};
        nexp  = '{32, 1};
        for (int t = 0; t < 2; t++) begin
            bus.mem_burstlen = lens[t];
            rdreq_cnt = 0;
            for (int i = 0; i < nexp[t]; i++) exp_rdreq_q.push_back(bases[t] + 32'(128 / nexp[t] * i));
            drive(bases[t], 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
            wait_idle(1000, ok);
            n_checks++;
            if (!ok || rdreq_cnt !== nexp[t] || exp_rdreq_q.size() !== 0)
                $display("FAIL burstlen_%0d: got done=%b bursts=%0d pending=%0d expected 1/%0d/0",
                         lens[t], ok, rdreq_cnt, exp_rdreq_q.size(), nexp[t]);
            else n_pass++;
            load_model(bases[t]);
            exp_rd_q.push_back(memval(bases[t] + 32'h7C));
            drive(bases[t] + 32'h7C, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
            n_checks++;
            if (exp_rd_q.size() !== 0 || bus.rsp_valid !== 1'b1)
                $display("FAIL burstlen_%0d_read: got pending=%0d valid=%b expected 0/1",
                         lens[t], exp_rd_q.size(), bus.rsp_valid);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_fill();
        bus.mem_burstlen = 16'd8;
        for (int i = 0; i < 4; i++) exp_rdreq_q.push_back(32'h0000_1000 + 32'(32 * i));
        drive(32'h0000_1000, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
        idle(12);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.miss !== 1'b1 || bus.ttl !== 8'd0 || bus.mem_rdreq !== 1'b0)
            $display("FAIL mid_fill_reset: got busy=%b miss=%b ttl=%0d rdreq=%b expected 0/1/0/0",
                     bus.busy, bus.miss, bus.ttl, bus.mem_rdreq);
        else n_pass++;
        idle(2);
        reset_n = 1'b1;
        exp_rdreq_q.delete();
        drive(32'h0000_1000, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
        idle(3);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.miss !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.mem_rdreq !== 1'b0)
            $display("FAIL after_reset_init: got busy=%b miss=%b valid=%b rdreq=%b expected 0/1/0/0",
                     bus.busy, bus.miss, bus.rsp_valid, bus.mem_rdreq);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read_hit();
        test_write_hit();
        test_miss();
        test_flush();
        test_back_to_back();
        test_burstlen();
        test_reset_mid_fill();
        n_checks++;
        if (exp_rd_q.size() !== 0 || exp_wr_q.size() !== 0)
            $display("FAIL scoreboard_drain: got rd=%0d wr=%0d expected 0/0", exp_rd_q.size(), exp_wr_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no completion expected finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end
endmodule
